// File: rtl/mrfm_tx_deinterleave.sv
// Pops interleaved 16-bit words from the TX FIFO, stages one frame of up to four
// channels and presents it on ch0..ch3 when the interpolation strobe arrives.
module mrfm_tx_deinterleave #(
    parameter int FIFO_AW = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [3:0]         numchan,
    input  logic [15:0]        fifo_data,
    input  logic               fifo_empty,
    input  logic [FIFO_AW-1:0] fifo_usedw,
    output logic               fifo_rdreq,
    input  logic               tx_strobe,
    output logic [15:0]        ch0,
    output logic [15:0]        ch1,
    output logic [15:0]        ch2,
    output logic [15:0]        ch3,
    output logic               strobe_out,
    input  logic               clear_status,
    output logic               tx_underrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    // A channel count of 0 means one word per frame; anything above 4 saturates.
    function automatic logic [2:0] eff_numchan(input logic [3:0] nc);
        logic [2:0] n;
        if (nc == 4'd0) begin
            n = 3'd1;
        end else if (nc > 4'd4) begin
            n = 3'd4;
        end else begin
            n = nc[2:0];
        end
        return n;
    endfunction

    logic [1:0]  state_r;
    logic [2:0]  n_r;
    logic [2:0]  cnt_r;
    logic [15:0] stage_r [0:3];
    logic [15:0] ch_r    [0:3];
    logic        strobe_out_r;
    logic        underrun_r;
    logic        rdreq_s;
    logic [2:0]  eff_n_s;
    logic        frame_avail_s;

    assign eff_n_s       = eff_numchan(numchan);
    assign frame_avail_s = (fifo_usedw >= {{(FIFO_AW-3){1'b0}}, eff_n_s});

    // Pop request: show-ahead FIFO, so the head word is captured on the same edge.
    always_comb begin
        rdreq_s = 1'b0;
        if (!reset && enable && (state_r == ST_FETCH) && !fifo_empty) begin
            rdreq_s = 1'b1;
        end else begin
            rdreq_s = 1'b0;
        end
    end

    // Frame fetch state machine, output frame registers and sticky underrun flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            n_r          <= 3'd1;
            cnt_r        <= 3'd0;
            strobe_out_r <= 1'b0;
            underrun_r   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                stage_r[k] <= 16'h0000;
                ch_r[k]    <= 16'h0000;
            end
        end else if (!enable) begin
            // Disabled: drop any partial frame; strobes are ignored entirely.
            state_r      <= ST_IDLE;
            cnt_r        <= 3'd0;
            strobe_out_r <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                stage_r[k] <= 16'h0000;
                ch_r[k]    <= 16'h0000;
            end
            if (clear_status) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
        end else begin
            strobe_out_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (frame_avail_s) begin
                        n_r     <= eff_n_s;
                        cnt_r   <= 3'd0;
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (rdreq_s) begin
                        stage_r[cnt_r[1:0]] <= fifo_data;
                        cnt_r               <= cnt_r + 3'd1;
                        if (cnt_r == (n_r - 3'd1)) begin
                            state_r <= ST_READY;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_READY: begin
                    if (tx_strobe) begin
                        for (int k = 0; k < 4; k++) begin
                            ch_r[k] <= (3'(k) < n_r) ? stage_r[k] : 16'h0000;
                        end
                        strobe_out_r <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_READY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // A strobe with no complete frame emits zeros; set beats clear.
            if (tx_strobe && (state_r != ST_READY)) begin
                for (int k = 0; k < 4; k++) begin
                    ch_r[k] <= 16'h0000;
                end
                strobe_out_r <= 1'b1;
                underrun_r   <= 1'b1;
            end else if (clear_status) begin
                underrun_r <= 1'b0;
            end else begin
                underrun_r <= underrun_r;
            end
        end
    end

    assign fifo_rdreq  = rdreq_s;
    assign ch0         = ch_r[0];
    assign ch1         = ch_r[1];
    assign ch2         = ch_r[2];
    assign ch3         = ch_r[3];
    assign strobe_out  = strobe_out_r;
    assign tx_underrun = underrun_r;

endmodule

// File: tb/tb_mrfm_tx_deinterleave.sv
// Directed bench for mrfm_tx_deinterleave with a small show-ahead FIFO model.
module tb_mrfm_tx_deinterleave;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [3:0]  numchan;
    logic [15:0] fifo_data;
    logic        fifo_empty;
    logic [11:0] fifo_usedw;
    logic        fifo_rdreq;
    logic        tx_strobe;
    logic [15:0] ch0, ch1, ch2, ch3;
    logic        strobe_out;
    logic        clear_status;
    logic        tx_underrun;

    logic [15:0] mem [0:255];
    logic [11:0] rd_ptr;
    logic [11:0] wr_ptr;
    int          pops;
    int          p0;
    int          n_checks;
    int          n_errors;

    assign fifo_data  = mem[rd_ptr[7:0]];
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_usedw = wr_ptr - rd_ptr;

    mrfm_tx_deinterleave #(.FIFO_AW(12)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .numchan      (numchan),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_usedw   (fifo_usedw),
        .fifo_rdreq   (fifo_rdreq),
        .tx_strobe    (tx_strobe),
        .ch0          (ch0),
        .ch1          (ch1),
        .ch2          (ch2),
        .ch3          (ch3),
        .strobe_out   (strobe_out),
        .clear_status (clear_status),
        .tx_underrun  (tx_underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 12'd1;
    endtask

    // One clock, entered and left on a negedge; pops the model FIFO if rdreq was high.
    task automatic cyc();
        logic rd_v;
        #1;
        rd_v = fifo_rdreq;
        if (rd_v) check("rdreq_while_empty", {31'd0, fifo_empty}, 32'd0);
        @(posedge clock);
        #1;
        if (rd_v) begin
            rd_ptr = rd_ptr + 12'd1;
            pops   = pops + 1;
        end
        @(negedge clock);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic strobe();
        tx_strobe = 1'b1;
        cyc();
        tx_strobe = 1'b0;
    endtask

    task automatic check_ch(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
        check({tag, "_ch0"}, {16'd0, ch0}, {16'd0, e0});
        check({tag, "_ch1"}, {16'd0, ch1}, {16'd0, e1});
        check({tag, "_ch2"}, {16'd0, ch2}, {16'd0, e2});
        check({tag, "_ch3"}, {16'd0, ch3}, {16'd0, e3});
    endtask

    initial begin
        n_checks = 0; n_errors = 0; pops = 0;
        rd_ptr = 12'd0; wr_ptr = 12'd0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset = 1'b1; enable = 1'b1; numchan = 4'd2;
        tx_strobe = 1'b0; clear_status = 1'b0;
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        @(negedge clock);
        wait_cycles(2);

        // Reset state
        check_ch("rst", 16'h0, 16'h0, 16'h0, 16'h0);
        check("rst_strobe_out", {31'd0, strobe_out}, 32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("rst_rdreq", {31'd0, fifo_rdreq}, 32'd0);
        check("rst_pops", pops, 0);

        // numchan=2, strobe every 16 cycles
        reset = 1'b0;
        wait_cycles(15);
        check("n2_fetch1_pops", pops, 2);
        strobe();
        check("n2_s1_strobe_out", {31'd0, strobe_out}, 32'd1);
        check_ch("n2_s1", 16'h1111, 16'h2222, 16'h0, 16'h0);
        cyc();
        check("n2_s1_pulse_width", {31'd0, strobe_out}, 32'd0);
        wait_cycles(14);
        check("n2_fetch2_pops", pops, 4);
        strobe();
        check("n2_s2_strobe_out", {31'd0, strobe_out}, 32'd1);
        check_ch("n2_s2", 16'h3333, 16'h4444, 16'h0, 16'h0);
        cyc();
        check("n2_s2_pulse_width", {31'd0, strobe_out}, 32'd0);
        check("n2_total_pops", pops, 4);
        check("n2_underrun", {31'd0, tx_underrun}, 32'd0);

        // numchan=4 with only 3 words: underrun
        numchan = 4'd4;
        p0 = pops;
        push(16'hAAA1); push(16'hAAA2); push(16'hAAA3);
        wait_cycles(10);
        check("short_no_pop", pops - p0, 0);
        strobe();
        check("short_strobe_out", {31'd0, strobe_out}, 32'd1);
        check("short_underrun", {31'd0, tx_underrun}, 32'd1);
        check_ch("short", 16'h0, 16'h0, 16'h0, 16'h0);
        cyc();
        push(16'hAAA4);
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
        check("clear_underrun", {31'd0, tx_underrun}, 32'd0);
        wait_cycles(8);
        check("full_pops", pops - p0, 4);
        strobe();
        check_ch("full", 16'hAAA1, 16'hAAA2, 16'hAAA3, 16'hAAA4);
        check("full_underrun", {31'd0, tx_underrun}, 32'd0);

        // numchan=0 behaves as 1, numchan=9 as 4
        numchan = 4'd0;
        p0 = pops;
        push(16'hB001);
        wait_cycles(6);
        check("n0_pops", pops - p0, 1);
        strobe();
        check_ch("n0", 16'hB001, 16'h0, 16'h0, 16'h0);
        numchan = 4'd9;
        p0 = pops;
        push(16'hC001); push(16'hC002); push(16'hC003); push(16'hC004);
        wait_cycles(8);
        check("n9_pops", pops - p0, 4);
        strobe();
        check_ch("n9", 16'hC001, 16'hC002, 16'hC003, 16'hC004);

        // numchan 4->1 changed during FETCH
        numchan = 4'd4;
        p0 = pops;
        push(16'hD001); push(16'hD002); push(16'hD003); push(16'hD004); push(16'hD005);
        cyc();
        numchan = 4'd1;
        wait_cycles(8);
        check("sw_frame1_pops", pops - p0, 4);
        strobe();
        check_ch("sw_f1", 16'hD001, 16'hD002, 16'hD003, 16'hD004);
        wait_cycles(6);
        check("sw_frame2_pops", pops - p0, 5);
        strobe();
        check_ch("sw_f2", 16'hD005, 16'h0, 16'h0, 16'h0);

        // clear_status and an underrun strobe in the same cycle
        tx_strobe = 1'b1; clear_status = 1'b1;
        cyc();
        tx_strobe = 1'b0; clear_status = 1'b0;
        check("setclr_underrun", {31'd0, tx_underrun}, 32'd1);
        check("setclr_strobe_out", {31'd0, strobe_out}, 32'd1);
        check("setclr_ch0", {16'd0, ch0}, 32'd0);
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
        check("setclr_cleared", {31'd0, tx_underrun}, 32'd0);

        // Reset mid-FETCH
        numchan = 4'd4;
        p0 = pops;
        push(16'hE001); push(16'hE002); push(16'hE003); push(16'hE004);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        check("rstf_pops", pops - p0, 1);
        check("rstf_rdreq", {31'd0, fifo_rdreq}, 32'd0);
        check("rstf_strobe_out", {31'd0, strobe_out}, 32'd0);
        check_ch("rstf", 16'h0, 16'h0, 16'h0, 16'h0);
        rd_ptr = wr_ptr;
        cyc();
        reset = 1'b0;
        enable = 1'b0;
        strobe();
        check("rstf_dis_strobe_out", {31'd0, strobe_out}, 32'd0);
        check("rstf_dis_underrun", {31'd0, tx_underrun}, 32'd0);

        // enable dropped while READY
        enable = 1'b1;
        numchan = 4'd2;
        p0 = pops;
        push(16'hF001); push(16'hF002); push(16'hF003); push(16'hF004);
        wait_cycles(6);
        strobe();
        check_ch("en_f1", 16'hF001, 16'hF002, 16'h0, 16'h0);
        wait_cycles(5);
        check("en_pops", pops - p0, 4);
        enable = 1'b0;
        cyc();
        check_ch("en_off", 16'h0, 16'h0, 16'h0, 16'h0);
        check("en_off_strobe_out", {31'd0, strobe_out}, 32'd0);
        check("en_off_rdreq", {31'd0, fifo_rdreq}, 32'd0);
        strobe();
        check("en_off_strobe_ignored", {31'd0, strobe_out}, 32'd0);
        check("en_off_no_underrun", {31'd0, tx_underrun}, 32'd0);
        enable = 1'b1;
        cyc();
        strobe();
        check("en_on_idle_underrun", {31'd0, tx_underrun}, 32'd1);
        check("en_on_strobe_out", {31'd0, strobe_out}, 32'd1);
        check_ch("en_on", 16'h0, 16'h0, 16'h0, 16'h0);
        check("en_final_pops", pops - p0, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mrfm_tx_deinterleave.md
Name: mrfm_tx_deinterleave

Overview:
- Transmit-side counterpart of the RX packing path: pops interleaved 16-bit sample words from the clk64-domain side of the TX USB FIFO.
- De-interleaves the words into up to four channel registers and presents one complete frame per interpolation strobe to the DAC mux/mrfm_proc path.
- Owns the tx_underrun status reported on FX2_3.

Parameters:
- FIFO_AW, 12, width of fifo_usedw (FIFO depth = 2^FIFO_AW words).

Ports:
- clock  in  1  master clock (clk64); all logic is on the rising edge.
- reset  in  1  synchronous, active-high; driven from tx_dsp_reset.
- enable  in  1  enable_tx from master_control.
- numchan  in  4  words per frame, from the FR_TX_MUX tx_numchan field. 0 is treated as 1; values >4 are clamped to 4.
- fifo_data  in  16  show-ahead FIFO head word, valid whenever fifo_empty=0.
- fifo_empty  in  1  FIFO empty.
- fifo_usedw  in  FIFO_AW  FIFO occupancy in words.
- fifo_rdreq  out  1  pop the head word.
- tx_strobe  in  1  one-cycle interpolation strobe (strobe_interp).
- ch0, ch1, ch2, ch3  out  16 each  current frame; word k of a frame goes to chk.
- strobe_out  out  1  one-cycle pulse marking new ch0..ch3 values.
- clear_status  in  1  clears the sticky underrun flag.
- tx_underrun  out  1  sticky underrun flag.

Behaviour:
- Reset: state IDLE; ch0..ch3=0, strobe_out=0, fifo_rdreq=0, tx_underrun=0, staging registers=0, word counter=0.
- State machine:
  - IDLE: if enable=1 and fifo_usedw >= n (n = effective numchan), latch n, clear the word counter, and go to FETCH next cycle. Otherwise stay in IDLE.
  - FETCH: fifo_rdreq = !fifo_empty. When rdreq=1, capture fifo_data into stage[counter] in the same cycle and increment the counter. After the n-th pop, go to READY. rdreq is never asserted while fifo_empty=1.
  - READY: hold staging and wait for tx_strobe.
- Fetch timing:
  - A frame is READY n+1 cycles after the IDLE entry condition holds.
  - Only whole frames are fetched; the usedw check guarantees no partial pop under normal operation.
- Strobe handling: tx_strobe is sampled in every state.
  - In READY: on the next cycle, ch0..ch(n-1) <= stage, unused channels <= 0, strobe_out=1, and the state goes to IDLE. A new fetch may start that same IDLE cycle.
  - Not READY with enable=1: underrun. On the next cycle ch0..ch3 <= 0, strobe_out=1, tx_underrun <= 1. Any in-progress fetch continues unaffected.
  - Latency from strobe to output is exactly 1 cycle in both cases.
- numchan is sampled only on the IDLE->FETCH transition. Changes mid-frame take effect on the next frame.
- enable=0: state forced to IDLE, fifo_rdreq=0, staging discarded, ch0..ch3 <= 0, strobe_out=0, tx_strobe ignored, no underrun recorded. Words already popped are lost; the host must reset the bus after disable.
- tx_underrun: set on an underrun event, cleared by clear_status. If both occur in the same cycle, set wins.
- Reset asserted mid-FETCH: aborts immediately to the reset state. The FIFO itself is reset by tx_bus_reset, outside this block.
- Back-to-back strobes (1 cycle apart): the second strobe is an underrun, because a refetch needs at least n+2 cycles.

Test Plan:
- numchan=2, FIFO preloaded 0x1111,0x2222,0x3333,0x4444, tx_strobe every 16 cycles:
  - 1st strobe gives ch0=0x1111, ch1=0x2222, ch2=ch3=0.
  - 2nd strobe gives 0x3333/0x4444.
  - strobe_out pulses exactly 1 cycle after each strobe; exactly 4 rdreq pulses total; tx_underrun stays 0.
- numchan=4, FIFO holding only 3 words, tx_strobe:
  - fifo_rdreq never asserted; outputs 0; strobe_out pulses; tx_underrun=1.
  - Then push a 4th word, pulse clear_status, strobe 8+ cycles later: ch0..ch3 = the 4 words, tx_underrun=0.
- numchan=0 and then numchan=9: behave as 1 and 4 words per frame respectively; check rdreq counts of 1 and 4 per frame.
- numchan switched 4->1 during FETCH: the current frame still pops 4 words; the next frame pops 1 and ch1..ch3=0.
- clear_status and an underrun strobe in the same cycle: tx_underrun=1 afterwards.
- Reset asserted mid-FETCH, and separately enable dropped while in READY: all outputs 0 on the next cycle, rdreq=0, state IDLE; subsequent tx_strobe with enable=0 produces no strobe_out and no underrun.
